// File: rtl/pipeline_interlock.sv
// Pipeline hazard interlock: load-use bubble, taken-branch flush and a
// multi-cycle multiply freeze, plus a saturating count of stalled cycles.
module pipeline_interlock #(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RtAddr,
    input  logic [4:0]       IF_ID_RsAddr,
    input  logic [4:0]       IF_ID_RtAddr,
    input  logic             ID_EX_MulOp,
    input  logic             EX_BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             MulBusy,
    output logic             MulDone,
    output logic [CNT_W-1:0] StallCount
);

    localparam int unsigned CNT_BITS = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [CNT_BITS-1:0] cnt, cnt_next;
    logic                lu;

    // Load in EX writes a register the instruction in ID reads; r0 never hazards.
    assign lu = ID_EX_MemRead && (ID_EX_RtAddr != 5'd0) &&
                ((ID_EX_RtAddr == IF_ID_RsAddr) || (ID_EX_RtAddr == IF_ID_RtAddr));

    // Next-state and combinational control outputs.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MulBusy      = 1'b0;
        MulDone      = 1'b0;

        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (EX_BranchTaken) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (ID_EX_MulOp) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        MulBusy      = 1'b1;
                        cnt_next     = CNT_BITS'(MUL_LATENCY - 1);
                        state_next   = MUL_WAIT;
                    end else if (lu) begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    if (cnt != '0) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        MulBusy      = 1'b1;
                        cnt_next     = cnt - CNT_BITS'(1);
                    end else begin
                        // Release cycle: the multiply that is still in EX must not retrigger.
                        MulDone    = 1'b1;
                        state_next = RUN;
                        if (lu) begin
                            PCWrite     = 1'b0;
                            IF_ID_Write = 1'b0;
                            ID_EX_Flush = 1'b1;
                        end
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // State, multiply countdown and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            StallCount <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (!PCWrite && (StallCount != {CNT_W{1'b1}})) begin
                StallCount <= StallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_interlock.sv
// Bench for pipeline_interlock: fixed vectors, hand-built multi-cycle
// sequences and random traffic against an age-based reference model.
module tb_pipeline_interlock;

    localparam int L   = 4;
    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;

    // Control byte: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
    //                ID_EX_Flush, EX_MEM_Flush, MulBusy, MulDone}
    localparam logic [7:0] DEF    = 8'b1101_0000;
    localparam logic [7:0] LUB    = 8'b0001_1000;
    localparam logic [7:0] BRF    = 8'b1111_1000;
    localparam logic [7:0] FRZ    = 8'b0000_0110;
    localparam logic [7:0] REL    = 8'b1101_0001;
    localparam logic [7:0] REL_LU = 8'b0001_1001;

    logic          clk = 1'b0;
    logic          rst;
    logic          ID_EX_MemRead;
    logic [4:0]    ID_EX_RtAddr;
    logic [4:0]    IF_ID_RsAddr;
    logic [4:0]    IF_ID_RtAddr;
    logic          ID_EX_MulOp;
    logic          EX_BranchTaken;
    logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
    logic          ID_EX_Flush, EX_MEM_Flush, MulBusy, MulDone;
    logic [CW-1:0] StallCount;

    always #5 clk = ~clk;

    pipeline_interlock #(.MUL_LATENCY(L), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_RtAddr   (ID_EX_RtAddr),
        .IF_ID_RsAddr   (IF_ID_RsAddr),
        .IF_ID_RtAddr   (IF_ID_RtAddr),
        .ID_EX_MulOp    (ID_EX_MulOp),
        .EX_BranchTaken (EX_BranchTaken),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Write    (ID_EX_Write),
        .ID_EX_Flush    (ID_EX_Flush),
        .EX_MEM_Flush   (EX_MEM_Flush),
        .MulBusy        (MulBusy),
        .MulDone        (MulDone),
        .StallCount     (StallCount)
    );

    typedef struct {
        logic       r;
        logic       mr;
        logic [4:0] rtex;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mul;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    int checks = 0;
    int fails  = 0;
    int age    = -1;   // cycles since multiply trigger, -1 when none in flight
    int mcount = 0;

    function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] rtex,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic mul, input logic br, input logic [7:0] exp);
        vec_t v;
        v.r = r; v.mr = mr; v.rtex = rtex; v.rs = rs; v.rt = rt;
        v.mul = mul; v.br = br; v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] model_out(input vec_t v, input int a);
        logic hz;
        hz = v.mr && (v.rtex != 5'd0) && ((v.rtex == v.rs) || (v.rtex == v.rt));
        if (v.r)              return DEF;
        if (a >= 1 && a < L)  return FRZ;
        if (a == L)           return hz ? REL_LU : REL;
        if (v.br)             return BRF;
        if (v.mul)            return FRZ;
        if (hz)               return LUB;
        return DEF;
    endfunction

    function automatic int model_next_age(input vec_t v, input int a);
        if (v.r)              return -1;
        if (a >= 1 && a < L)  return a + 1;
        if (a == L)           return -1;
        if (!v.br && v.mul)   return 1;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare outputs, then advance the model across the edge.
    task automatic run_cycle(input vec_t v, input logic use_exp, input string name);
        logic [7:0] act, exp, mexp;
        @(negedge clk);
        rst            = v.r;
        ID_EX_MemRead  = v.mr;
        ID_EX_RtAddr   = v.rtex;
        IF_ID_RsAddr   = v.rs;
        IF_ID_RtAddr   = v.rt;
        ID_EX_MulOp    = v.mul;
        EX_BranchTaken = v.br;
        #1;
        mexp = model_out(v, age);
        exp  = use_exp ? v.exp : mexp;
        act  = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                ID_EX_Flush, EX_MEM_Flush, MulBusy, MulDone};
        check({name, "_ctrl"}, int'(act), int'(exp));
        check({name, "_count"}, int'(StallCount), mcount);
        if (v.r)                           mcount = 0;
        else if (!mexp[7] && mcount < MAX) mcount = mcount + 1;
        age = model_next_age(v, age);
    endtask

    vec_t tbl[8];
    vec_t idle;
    int   base;

    initial begin
        idle = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, DEF);

        tbl[0] = mk(1, 1, 5'd8, 5'd8, 5'd3, 1, 0, DEF);   // reset overrides hazard and mul
        tbl[1] = mk(0, 1, 5'd8, 5'd8, 5'd3, 0, 0, LUB);   // load-use on rs
        tbl[2] = mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, DEF);   // r0 never hazards
        tbl[3] = mk(0, 1, 5'd5, 5'd1, 5'd5, 0, 0, LUB);   // load-use on rt
        tbl[4] = mk(0, 0, 5'd5, 5'd5, 5'd5, 0, 0, DEF);   // not a load
        tbl[5] = mk(0, 1, 5'd8, 5'd8, 5'd8, 1, 1, BRF);   // branch beats mul and hazard
        tbl[6] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, BRF);   // branch alone
        tbl[7] = mk(0, 1, 5'd9, 5'd1, 5'd2, 0, 0, DEF);   // load without match

        rst = 1'b1; ID_EX_MemRead = 1'b0; ID_EX_RtAddr = '0; IF_ID_RsAddr = '0;
        IF_ID_RtAddr = '0; ID_EX_MulOp = 1'b0; EX_BranchTaken = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        check("lu_stall_total", int'(StallCount), 2);

        // Multiply: four frozen cycles with inputs ignored, release ignores the same mul,
        // then a back-to-back mul retriggers.
        base = mcount;
        run_cycle(mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, FRZ), 1'b1, "mul_t0");
        for (int k = 1; k < L; k++)
            run_cycle(mk(0, 1, 5'd4, 5'd4, 5'd4, 1, 1, FRZ), 1'b1, $sformatf("mul_t%0d", k));
        run_cycle(mk(0, 1, 5'd4, 5'd4, 5'd0, 1, 0, REL_LU), 1'b1, "mul_release");
        run_cycle(mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, FRZ), 1'b1, "mul_b2b");
        for (int k = 1; k < L; k++) run_cycle(idle, 1'b0, $sformatf("mul2_t%0d", k));
        run_cycle(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, REL), 1'b1, "mul2_release");
        run_cycle(idle, 1'b1, "mul2_after");
        check("mul_stall_total", int'(StallCount), base + 2 * L + 1);

        // Reset in the middle of a multiply abandons it without MulDone.
        run_cycle(mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, FRZ), 1'b1, "rstmul_t0");
        run_cycle(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRZ), 1'b1, "rstmul_t1");
        run_cycle(mk(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, DEF), 1'b1, "rstmul_t2");
        for (int k = 0; k < L + 1; k++) run_cycle(idle, 1'b1, $sformatf("rstmul_idle%0d", k));
        check("rstmul_count", int'(StallCount), 0);

        // Continuous load-use drives the counter into saturation.
        for (int k = 0; k < MAX + 10; k++)
            run_cycle(mk(0, 1, 5'd7, 5'd7, 5'd1, 0, 0, LUB), 1'b1, "sat");
        check("sat_count", int'(StallCount), MAX);

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            vec_t v;
            v = mk(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 5) == 0), DEF);
            run_cycle(v, 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_interlock.md
PIPELINE_INTERLOCK -- requirements
Module: pipeline_interlock

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 4, meaning the number of cycles the EX-stage multiplier occupies EX; legal range 2..15.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall performance counter.
REQ-003 SHALL have one clock and a synchronous, active-high reset, declared first as below.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-007 ID_EX_RtAddr  input  5  load destination register in EX.
REQ-008 IF_ID_RsAddr  input  5  rs of instruction in ID.
REQ-009 IF_ID_RtAddr  input  5  rt of instruction in ID.
REQ-010 ID_EX_MulOp  input  1  instruction in EX is a multi-cycle multiply.
REQ-011 EX_BranchTaken  input  1  branch/jump in EX resolved taken.
REQ-012 PCWrite  output  1  PC update enable.
REQ-013 IF_ID_Write  output  1  IF/ID register load enable.
REQ-014 IF_ID_Flush  output  1  zero IF/ID at next edge.
REQ-015 ID_EX_Write  output  1  ID/EX register load enable.
REQ-016 ID_EX_Flush  output  1  load bubble into ID/EX at next edge.
REQ-017 EX_MEM_Flush  output  1  load bubble into EX/MEM at next edge.
REQ-018 MulBusy  output  1  multiply stall active this cycle.
REQ-019 MulDone  output  1  multiply result valid in EX this cycle (release cycle).
REQ-020 StallCount  output  CNT_W  number of cycles with PCWrite=0 since reset.

Function
REQ-021 SHALL implement a 2-state FSM, RUN and MUL_WAIT, plus a down-counter cnt of 4 bits.
REQ-022 Default outputs: all Write enables 1, all Flush, MulBusy and MulDone 0.
REQ-023 Load-use hazard LU = ID_EX_MemRead && ID_EX_RtAddr!=0 && (ID_EX_RtAddr==IF_ID_RsAddr || ID_EX_RtAddr==IF_ID_RtAddr).
REQ-024 In RUN, priority SHALL be EX_BranchTaken > ID_EX_MulOp > LU.
REQ-025 RUN + EX_BranchTaken: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1; stay RUN; MulOp and LU ignored that cycle.
REQ-026 RUN + ID_EX_MulOp (no branch): PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Flush=1, MulBusy=1; cnt<=MUL_LATENCY-1; next state MUL_WAIT.
REQ-027 RUN + LU only: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly that cycle; stay RUN (the bubble removes the hazard without further state).
REQ-028 MUL_WAIT, cnt!=0: same outputs as REQ-026; cnt<=cnt-1; all inputs ignored.
REQ-029 MUL_WAIT, cnt==0: release cycle: MulDone=1, MulBusy=0, enables as default except LU evaluated per REQ-027; next state RUN; ID_EX_MulOp ignored this cycle (the same multiply must not retrigger).
REQ-030 Total frozen cycles per multiply SHALL equal MUL_LATENCY; release cycle occurs MUL_LATENCY cycles after trigger cycle.
REQ-031 Outputs other than StallCount SHALL be combinational from state, cnt and inputs; no added latency.
REQ-032 StallCount SHALL increment by 1 at each edge where PCWrite=0 and rst=0, saturating at all-ones (no wrap).
REQ-033 Back-to-back multiplies: a new ID_EX_MulOp seen in the first RUN cycle after release SHALL retrigger per REQ-026.

Reset
REQ-034 While rst=1, outputs SHALL be default values (REQ-022) and StallCount=0 regardless of other inputs.
REQ-035 At an edge with rst=1: state<=RUN, cnt<=0, StallCount<=0; reset in MUL_WAIT abandons the multiply with no MulDone.

Verification
REQ-036 ID_EX_MemRead=1, ID_EX_RtAddr=8, IF_ID_RsAddr=8 for one cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle only; StallCount 0->1.
REQ-037 Same as REQ-036 but ID_EX_RtAddr=0 -> no stall, StallCount unchanged.
REQ-038 MUL_LATENCY=4, ID_EX_MulOp=1 at cycle T -> MulBusy=1, PCWrite=0 cycles T..T+3; MulDone=1 at T+4 only; StallCount=4.
REQ-039 EX_BranchTaken=1 with ID_EX_MulOp=1 and LU true -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, state stays RUN.
REQ-040 rst=1 at T+2 of a multiply -> next cycle RUN, default outputs, StallCount=0, no MulDone; force StallCount to all-ones then stall -> stays all-ones.
